// File: rtl/video_cfg_bank.sv
// Multi-profile video timing register bank: MCU programs inactive profiles,
// the active one switches atomically on flyback, on force, or on timeout.
module video_cfg_bank #(
  parameter int NUM_SETS       = 2,
  parameter int COORD_W        = 11,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FRAME_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  input  logic [7:0]         reg_addr,
  input  logic               reg_wstrobe,
  input  logic               sync_flybk,
  output logic [COORD_W-1:0] o_res_x,
  output logic [COORD_W-1:0] o_hs_fp,
  output logic [COORD_W-1:0] o_hs_width,
  output logic [COORD_W-1:0] o_hs_bp,
  output logic [COORD_W-1:0] o_res_y,
  output logic [COORD_W-1:0] o_vs_fp,
  output logic [COORD_W-1:0] o_vs_width,
  output logic [COORD_W-1:0] o_vs_bp,
  output logic [COORD_W-1:0] o_cursor_x_offset,
  output logic [7:0]         o_wpl_m1,
  output logic [2:0]         o_bpp,
  output logic               o_hires,
  output logic               o_double_x,
  output logic               o_double_y,
  output logic [1:0]         o_active_set,
  output logic               cfg_update,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]    NSETS   = 3'(NUM_SETS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [COORD_W-1:0] RST_RES_X = COORD_W'(640);
  localparam logic [COORD_W-1:0] RST_HS_FP = COORD_W'(40);
  localparam logic [COORD_W-1:0] RST_HS_W  = COORD_W'(20);
  localparam logic [COORD_W-1:0] RST_HS_BP = COORD_W'(68);
  localparam logic [COORD_W-1:0] RST_RES_Y = COORD_W'(256);
  localparam logic [COORD_W-1:0] RST_VS_FP = COORD_W'(40);
  localparam logic [COORD_W-1:0] RST_VS_W  = COORD_W'(5);
  localparam logic [COORD_W-1:0] RST_VS_BP = COORD_W'(67);
  localparam logic [COORD_W-1:0] RST_CURS  = COORD_W'(217);

  typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} state_t;

  function automatic logic [31:0] ext_c(input logic [COORD_W-1:0] v);
    return {{(32-COORD_W){1'b0}}, v};
  endfunction

  // Profile storage is always four deep; sets >= NUM_SETS are never written.
  logic [COORD_W-1:0] r_res_x [4];
  logic [COORD_W-1:0] r_hs_fp [4];
  logic [COORD_W-1:0] r_hs_w  [4];
  logic [COORD_W-1:0] r_hs_bp [4];
  logic [COORD_W-1:0] r_res_y [4];
  logic [COORD_W-1:0] r_vs_fp [4];
  logic [COORD_W-1:0] r_vs_w  [4];
  logic [COORD_W-1:0] r_vs_bp [4];
  logic [COORD_W-1:0] r_curs  [4];
  logic [7:0]         r_wpl   [4];
  logic [2:0]         r_bpp   [4];
  logic               r_hires [4];
  logic               r_dbl_x [4];
  logic               r_dbl_y [4];

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_flybk_d, r_edge;
  logic [FRAME_W-1:0]     r_frame;
  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_active, w_active_nxt, r_target, w_target_nxt;
  logic [TW-1:0]          r_cnt, w_cnt_nxt;
  logic                   w_apply, w_timeout_hit;
  logic                   r_cfg_update, r_err_wr, r_timeout, r_err_bad;

  logic [1:0] w_set, w_tgt, w_pend_tgt;
  logic [3:0] w_idx;
  logic       w_set_ok, w_tgt_ok, w_ctrl_wr, w_commit, w_force, w_clear, w_bad;
  logic       w_set_wr, w_wr_act, w_cfg_wr, w_flybk;
  logic       w_unused;

  assign w_set      = reg_addr[7:6];
  assign w_idx      = reg_addr[5:2];
  assign w_set_ok   = ({1'b0, w_set} < NSETS);
  assign w_tgt      = reg_wdata[5:4];
  assign w_tgt_ok   = ({1'b0, w_tgt} < NSETS);
  assign w_ctrl_wr  = reg_wstrobe & w_set_ok & (w_idx == 4'hC);
  assign w_commit   = w_ctrl_wr & reg_wdata[0];
  assign w_force    = w_ctrl_wr & reg_wdata[1];
  assign w_clear    = w_ctrl_wr & reg_wdata[8];
  assign w_bad      = w_ctrl_wr & (reg_wdata[0] | reg_wdata[1]) & ~w_tgt_ok;
  assign w_set_wr   = reg_wstrobe & w_set_ok & (w_idx <= 4'd9);
  assign w_wr_act   = w_set_wr & (w_set == r_active);
  assign w_cfg_wr   = w_set_wr & (w_set != r_active);
  assign w_flybk    = r_sync[SYNC_STAGES-1];
  assign w_pend_tgt = (r_state == S_PENDING) ? r_target : 2'd0;
  assign w_unused   = ^{reg_wdata, reg_addr[1:0]};

  assign cfg_update   = r_cfg_update;
  assign frame_count  = r_frame;
  assign o_active_set = r_active;

  // Flyback synchroniser, edge detect and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '0;
      r_flybk_d <= 1'b0;
      r_edge    <= 1'b0;
      r_frame   <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], sync_flybk};
      r_flybk_d <= w_flybk;
      r_edge    <= w_flybk & ~r_flybk_d;
      r_frame   <= r_frame + FRAME_W'(r_edge);
    end
  end

  // Commit state machine next-state: force beats a commit write, which beats edge/timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_active_nxt  = r_active;
    w_target_nxt  = r_target;
    w_cnt_nxt     = r_cnt;
    w_apply       = 1'b0;
    w_timeout_hit = 1'b0;
    if (w_force && w_tgt_ok) begin
      w_active_nxt = w_tgt;
      w_apply      = 1'b1;
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
    end else if (w_commit && w_tgt_ok) begin
      w_state_nxt  = S_PENDING;
      w_target_nxt = w_tgt;
      w_cnt_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: w_cnt_nxt = '0;
        S_PENDING: begin
          if (r_edge || (r_cnt == TO_LAST)) begin
            w_active_nxt  = r_target;
            w_apply       = 1'b1;
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_timeout_hit = ~r_edge;
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Commit state register, update strobe and sticky flags (set wins over clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_active     <= 2'd0;
      r_target     <= 2'd0;
      r_cnt        <= '0;
      r_cfg_update <= 1'b0;
      r_err_wr     <= 1'b0;
      r_timeout    <= 1'b0;
      r_err_bad    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_active     <= w_active_nxt;
      r_target     <= w_target_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cfg_update <= w_apply;
      r_err_wr     <= (r_err_wr  & ~w_clear) | w_wr_act;
      r_timeout    <= (r_timeout & ~w_clear) | w_timeout_hit;
      r_err_bad    <= (r_err_bad & ~w_clear) | w_bad;
    end
  end

  // Profile register file writes (inactive sets only).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 4; s++) begin
        r_res_x[s] <= RST_RES_X;
        r_hs_fp[s] <= RST_HS_FP;
        r_hs_w[s]  <= RST_HS_W;
        r_hs_bp[s] <= RST_HS_BP;
        r_res_y[s] <= RST_RES_Y;
        r_vs_fp[s] <= RST_VS_FP;
        r_vs_w[s]  <= RST_VS_W;
        r_vs_bp[s] <= RST_VS_BP;
        r_curs[s]  <= RST_CURS;
        r_wpl[s]   <= 8'd79;
        r_bpp[s]   <= 3'd2;
        r_hires[s] <= 1'b0;
        r_dbl_x[s] <= 1'b0;
        r_dbl_y[s] <= 1'b1;
      end
    end else if (w_cfg_wr) begin
      case (w_idx)
        4'd0: begin
          r_res_x[w_set] <= reg_wdata[COORD_W-1:0];
          r_dbl_x[w_set] <= reg_wdata[31];
        end
        4'd1: r_hs_fp[w_set] <= reg_wdata[COORD_W-1:0];
        4'd2: r_hs_w[w_set]  <= reg_wdata[COORD_W-1:0];
        4'd3: r_hs_bp[w_set] <= reg_wdata[COORD_W-1:0];
        4'd4: begin
          r_res_y[w_set] <= reg_wdata[COORD_W-1:0];
          r_dbl_y[w_set] <= reg_wdata[31];
        end
        4'd5: r_vs_fp[w_set] <= reg_wdata[COORD_W-1:0];
        4'd6: r_vs_w[w_set]  <= reg_wdata[COORD_W-1:0];
        4'd7: r_vs_bp[w_set] <= reg_wdata[COORD_W-1:0];
        4'd8: r_wpl[w_set]   <= reg_wdata[7:0];
        4'd9: begin
          r_hires[w_set] <= reg_wdata[31];
          r_bpp[w_set]   <= reg_wdata[30:28];
          r_curs[w_set]  <= reg_wdata[COORD_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Exported profile follows the next active index so it lands with cfg_update.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_res_x           <= RST_RES_X;
      o_hs_fp           <= RST_HS_FP;
      o_hs_width        <= RST_HS_W;
      o_hs_bp           <= RST_HS_BP;
      o_res_y           <= RST_RES_Y;
      o_vs_fp           <= RST_VS_FP;
      o_vs_width        <= RST_VS_W;
      o_vs_bp           <= RST_VS_BP;
      o_cursor_x_offset <= RST_CURS;
      o_wpl_m1          <= 8'd79;
      o_bpp             <= 3'd2;
      o_hires           <= 1'b0;
      o_double_x        <= 1'b0;
      o_double_y        <= 1'b1;
    end else begin
      o_res_x           <= r_res_x[w_active_nxt];
      o_hs_fp           <= r_hs_fp[w_active_nxt];
      o_hs_width        <= r_hs_w[w_active_nxt];
      o_hs_bp           <= r_hs_bp[w_active_nxt];
      o_res_y           <= r_res_y[w_active_nxt];
      o_vs_fp           <= r_vs_fp[w_active_nxt];
      o_vs_width        <= r_vs_w[w_active_nxt];
      o_vs_bp           <= r_vs_bp[w_active_nxt];
      o_cursor_x_offset <= r_curs[w_active_nxt];
      o_wpl_m1          <= r_wpl[w_active_nxt];
      o_bpp             <= r_bpp[w_active_nxt];
      o_hires           <= r_hires[w_active_nxt];
      o_double_x        <= r_dbl_x[w_active_nxt];
      o_double_y        <= r_dbl_y[w_active_nxt];
    end
  end

  // Combinational register read mux.
  always_comb begin
    reg_rdata = 32'd0;
    if (!w_set_ok) begin
      reg_rdata = 32'd0;
    end else begin
      case (w_idx)
        4'd0: reg_rdata = ext_c(r_res_x[w_set]) | {r_dbl_x[w_set], 31'd0};
        4'd1: reg_rdata = ext_c(r_hs_fp[w_set]);
        4'd2: reg_rdata = ext_c(r_hs_w[w_set]);
        4'd3: reg_rdata = ext_c(r_hs_bp[w_set]);
        4'd4: reg_rdata = ext_c(r_res_y[w_set]) | {r_dbl_y[w_set], 31'd0};
        4'd5: reg_rdata = ext_c(r_vs_fp[w_set]);
        4'd6: reg_rdata = ext_c(r_vs_w[w_set]);
        4'd7: reg_rdata = ext_c(r_vs_bp[w_set]);
        4'd8: reg_rdata = {24'd0, r_wpl[w_set]};
        4'd9: reg_rdata = ext_c(r_curs[w_set]) | {r_hires[w_set], r_bpp[w_set], 28'd0};
        4'hD: reg_rdata = {12'd0, r_err_bad, r_timeout, r_err_wr, w_flybk, 6'd0,
                           w_pend_tgt, 2'd0, r_active, 3'd0, (r_state == S_PENDING)};
        4'hE: reg_rdata = 32'(r_frame);
        default: reg_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_video_cfg_bank.sv
// Directed bench for video_cfg_bank: NUM_SETS=2, TIMEOUT_CYCLES=100, FRAME_W=8.
module tb_video_cfg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reg_wdata, reg_rdata;
  logic [7:0]  reg_addr;
  logic        reg_wstrobe, sync_flybk;
  logic [10:0] o_res_x, o_hs_fp, o_hs_width, o_hs_bp, o_res_y, o_vs_fp, o_vs_width, o_vs_bp, o_cursor_x_offset;
  logic [7:0]  o_wpl_m1;
  logic [2:0]  o_bpp;
  logic        o_hires, o_double_x, o_double_y;
  logic [1:0]  o_active_set;
  logic        cfg_update;
  logic [7:0]  frame_count;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;

  localparam logic [7:0] A_CTRL = 8'h30, A_STAT = 8'h34, A_FRM = 8'h38;

  always #5 clk = ~clk;

  video_cfg_bank #(.NUM_SETS(2), .COORD_W(11), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100), .FRAME_W(8)) dut (
    .clk(clk), .reset(reset), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_addr(reg_addr),
    .reg_wstrobe(reg_wstrobe), .sync_flybk(sync_flybk),
    .o_res_x(o_res_x), .o_hs_fp(o_hs_fp), .o_hs_width(o_hs_width), .o_hs_bp(o_hs_bp),
    .o_res_y(o_res_y), .o_vs_fp(o_vs_fp), .o_vs_width(o_vs_width), .o_vs_bp(o_vs_bp),
    .o_cursor_x_offset(o_cursor_x_offset), .o_wpl_m1(o_wpl_m1), .o_bpp(o_bpp), .o_hires(o_hires),
    .o_double_x(o_double_x), .o_double_y(o_double_y), .o_active_set(o_active_set),
    .cfg_update(cfg_update), .frame_count(frame_count)
  );

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_addr = a; reg_wdata = d; reg_wstrobe = 1'b1;
    @(negedge clk);
    reg_wstrobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  // One flyback pulse; returns the number of cfg_update cycles seen.
  task automatic pulse(output int n);
    n = 0;
    @(negedge clk);
    sync_flybk = 1'b1;
    repeat (6) begin @(negedge clk); if (cfg_update) n++; end
    sync_flybk = 1'b0;
    repeat (4) begin @(negedge clk); if (cfg_update) n++; end
    exp_frames++;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; sync_flybk = 1'b0; reg_wstrobe = 1'b0; reg_addr = 8'h00; reg_wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(8'h00, d); checks++;
    if (d !== 32'h0000_0280) begin failures++; $display("FAIL reset_idx0 got=%h exp=%h", d, 32'h280); end
    rd(8'h10, d); checks++;
    if (d !== 32'h8000_0100) begin failures++; $display("FAIL reset_idx4 got=%h exp=%h", d, 32'h80000100); end
    rd(8'h24, d); checks++;
    if (d !== 32'h2000_00D9) begin failures++; $display("FAIL reset_idx9 got=%h exp=%h", d, 32'h200000D9); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
    checks++;
    if (o_res_x !== 11'd640) begin failures++; $display("FAIL reset_o_res_x got=%0d exp=640", o_res_x); end
    checks++;
    if ({o_double_y, o_bpp, o_wpl_m1, o_active_set, cfg_update, frame_count} !== {1'b1, 3'd2, 8'd79, 2'd0, 1'b0, 8'd0}) begin
      failures++; $display("FAIL reset_outputs dy=%b bpp=%0d wpl=%0d act=%0d upd=%b frm=%0d", o_double_y, o_bpp, o_wpl_m1, o_active_set, cfg_update, frame_count);
    end
  endtask

  task automatic test_commit_flyback;
    logic [31:0] d;
    logic [10:0] rx;
    logic [1:0]  act;
    int bad = 0;
    wr(8'h40, 32'h480);
    rd(8'h40, d); checks++;
    if (d !== 32'h480) begin failures++; $display("FAIL set1_readback got=%h exp=480", d); end
    wr(A_CTRL, 32'h11);
    rd(A_STAT, d); checks++;
    if (d !== 32'h101) begin failures++; $display("FAIL pending_status got=%h exp=101", d); end
    @(negedge clk);
    sync_flybk = 1'b1;
    rx = 11'd0; act = 2'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (cfg_update !== (k == 4)) bad++;
      if (k == 4) begin rx = o_res_x; act = o_active_set; end
    end
    sync_flybk = 1'b0;
    repeat (4) @(negedge clk);
    exp_frames++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL update_latency wrong_cycles=%0d exp=0", bad); end
    checks++;
    if ({rx, act} !== {11'h480, 2'd1}) begin failures++; $display("FAIL apply_outputs res_x=%h act=%0d exp 480/1", rx, act); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h10) begin failures++; $display("FAIL applied_status got=%h exp=10", d); end
    checks++;
    if (frame_count !== 8'(exp_frames)) begin failures++; $display("FAIL frame_count got=%0d exp=%0d", frame_count, exp_frames); end
  endtask

  task automatic test_write_active;
    logic [31:0] d;
    wr(8'h44, 32'd99);
    rd(8'h44, d); checks++;
    if (d !== 32'd40 || o_hs_fp !== 11'd40) begin failures++; $display("FAIL wr_active_ignored reg=%0d out=%0d exp=40", d, o_hs_fp); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h0002_0010) begin failures++; $display("FAIL err_wr_active got=%h exp=20010", d); end
    wr(A_CTRL, 32'h100);
    rd(A_STAT, d); checks++;
    if (d !== 32'h10) begin failures++; $display("FAIL clear_sticky got=%h exp=10", d); end
    wr(8'h80, 32'h123);
    rd(8'h80, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL bad_set_read got=%h exp=0", d); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h10) begin failures++; $display("FAIL bad_set_noflag got=%h exp=10", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int n;
    wr(A_CTRL, 32'h11);
    wr(A_CTRL, 32'h01);
    wr(8'h00, 32'h300);
    rd(A_STAT, d); checks++;
    if (d !== 32'h11) begin failures++; $display("FAIL recommit_status got=%h exp=11", d); end
    pulse(n); checks++;
    if (n != 1 || o_active_set !== 2'd0 || o_res_x !== 11'h300) begin
      failures++; $display("FAIL recommit_apply upd=%0d act=%0d res_x=%h exp 1/0/300", n, o_active_set, o_res_x);
    end
    rd(A_STAT, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL recommit_final_status got=%h exp=0", d); end
    // Commit sampled on the same cycle the edge flag is high.
    @(negedge clk);
    sync_flybk = 1'b1;
    repeat (3) @(negedge clk);
    reg_addr = A_CTRL; reg_wdata = 32'h11; reg_wstrobe = 1'b1;
    n = 0;
    @(negedge clk);
    reg_wstrobe = 1'b0;
    if (cfg_update) n++;
    repeat (5) begin @(negedge clk); if (cfg_update) n++; end
    sync_flybk = 1'b0;
    repeat (4) begin @(negedge clk); if (cfg_update) n++; end
    exp_frames++;
    rd(A_STAT, d); checks++;
    if (n != 0 || d !== 32'h101) begin failures++; $display("FAIL coincident_wait upd=%0d status=%h exp 0/101", n, d); end
    pulse(n); checks++;
    if (n != 1 || o_active_set !== 2'd1) begin failures++; $display("FAIL coincident_next_edge upd=%0d act=%0d exp 1/1", n, o_active_set); end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    int found = 0;
    int k = 0;
    wr(A_CTRL, 32'h01);
    while (found == 0 && k < 150) begin
      @(negedge clk);
      k++;
      if (cfg_update) found = k;
    end
    checks++;
    if (found != 100) begin failures++; $display("FAIL timeout_cycle got=%0d exp=100", found); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h0004_0000 || o_active_set !== 2'd0) begin failures++; $display("FAIL timeout_status got=%h act=%0d exp 40000/0", d, o_active_set); end
    wr(A_CTRL, 32'h13);
    checks++;
    if (cfg_update !== 1'b1 || o_active_set !== 2'd1) begin failures++; $display("FAIL force_apply upd=%b act=%0d exp 1/1", cfg_update, o_active_set); end
    @(negedge clk);
    checks++;
    if (cfg_update !== 1'b0) begin failures++; $display("FAIL force_pulse_width upd=%b exp=0", cfg_update); end
    rd(A_STAT, d); checks++;
    if (d !== 32'h0004_0010) begin failures++; $display("FAIL force_status got=%h exp=40010", d); end
    wr(A_CTRL, 32'h100);
  endtask

  task automatic test_bad_target;
    logic [31:0] d;
    wr(A_CTRL, 32'h31);
    rd(A_STAT, d); checks++;
    if (d !== 32'h0008_0010) begin failures++; $display("FAIL bad_target_status got=%h exp=80010", d); end
    wr(A_CTRL, 32'h32);
    checks++;
    if (cfg_update !== 1'b0 || o_active_set !== 2'd1) begin failures++; $display("FAIL bad_force_ignored upd=%b act=%0d exp 0/1", cfg_update, o_active_set); end
    wr(A_CTRL, 32'h100);
    wr(A_CTRL, 32'h131);
    rd(A_STAT, d); checks++;
    if (d !== 32'h0008_0010) begin failures++; $display("FAIL set_beats_clear got=%h exp=80010", d); end
    wr(A_CTRL, 32'h100);
    rd(A_STAT, d); checks++;
    if (d !== 32'h10) begin failures++; $display("FAIL bad_target_cleared got=%h exp=10", d); end
  endtask

  task automatic test_frame_wrap;
    logic [31:0] d;
    int n;
    while ((exp_frames % 256) != 255) pulse(n);
    checks++;
    if (frame_count !== 8'hFF) begin failures++; $display("FAIL frame_pre_wrap got=%0d exp=255", frame_count); end
    pulse(n);
    rd(A_FRM, d); checks++;
    if (frame_count !== 8'h00 || d !== 32'h0) begin failures++; $display("FAIL frame_wrap port=%0d reg=%h exp 0", frame_count, d); end
  endtask

  task automatic test_reset_mid_pending;
    logic [31:0] d;
    int n;
    wr(A_CTRL, 32'h01);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(A_STAT, d); checks++;
    if (d !== 32'h0 || o_active_set !== 2'd0 || o_res_x !== 11'd640) begin
      failures++; $display("FAIL reset_pending status=%h act=%0d res_x=%0d exp 0/0/640", d, o_active_set, o_res_x);
    end
    pulse(n); checks++;
    if (n != 0 || o_active_set !== 2'd0) begin failures++; $display("FAIL reset_discards_commit upd=%0d act=%0d exp 0/0", n, o_active_set); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_commit_flyback();
    test_write_active();
    test_back_to_back();
    test_timeout();
    test_bad_target();
    test_frame_wrap();
    test_reset_mid_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
